// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int NUM_RD_DEF = 2;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} rf_state_e;
endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the register file: write port, packed read ports, clear handshake.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
);
  logic [DATA_W-1:0]        writeData;
  logic [ADDR_W-1:0]        writeReg;
  logic                     RegWriteControl;
  logic [NUM_RD*ADDR_W-1:0] readAddr;
  logic [NUM_RD*DATA_W-1:0] readData;
  logic                     clearReq;
  logic                     busy;
  logic                     wrDropped;

  modport master (
    output writeData, writeReg, RegWriteControl, readAddr, clearReq,
    input  readData, busy, wrDropped
  );

  modport slave (
    input  writeData, writeReg, RegWriteControl, readAddr, clearReq,
    output readData, busy, wrDropped
  );
endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep sequencer: walks a pointer over every register, one per clock,
// and flags writes that arrive while the sweep owns the array.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              clearReq,
  input  logic              wrEn,
  output logic              busy,
  output logic              wrDropped,
  output logic              clrEn,
  output logic [ADDR_W-1:0] clrAddr
);
  rf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      ptr       <= '0;
      busy      <= 1'b0;
      wrDropped <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      busy      <= (state_nxt == CLEAR);
      wrDropped <= wrEn && (state == CLEAR);
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    clrEn     = 1'b0;
    clrAddr   = ptr;
    unique case (state)
      IDLE: begin
        if (clearReq) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        // clearReq is ignored here; the last register wraps the pointer back to 0
        clrEn   = 1'b1;
        ptr_nxt = ptr + 1'b1;
        if (ptr == '1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: one write port, NUM_RD combinational read ports,
// optional hardwired r0, optional write-to-read bypass, and a multi-cycle clear sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic         CLK,
  input logic         RST_N,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic                         clr_en;
  logic [ADDR_W-1:0]            clr_addr;
  logic                         we;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clr (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .clearReq  (bus.clearReq),
    .wrEn      (bus.RegWriteControl),
    .busy      (bus.busy),
    .wrDropped (bus.wrDropped),
    .clrEn     (clr_en),
    .clrAddr   (clr_addr)
  );

  // Effective write: idle only, and r0 writes vanish when it is hardwired
  assign we = bus.RegWriteControl && !clr_en &&
              !(ZERO_REG && (bus.writeReg == '0));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      mem <= '0;
    else if (clr_en) mem[clr_addr] <= '0;
    else if (we)     mem[bus.writeReg] <= bus.writeData;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] stored;
    logic              hit;

    assign ra     = bus.readAddr[i*ADDR_W +: ADDR_W];
    assign stored = (ZERO_REG && (ra == '0)) ? '0 : mem[ra];
    assign hit    = BYPASS && we && (bus.writeReg == ra);
    assign bus.readData[i*DATA_W +: DATA_W] = hit ? bus.writeData : stored;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: bypass and non-bypass instances share one stimulus stream.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic        CLK, RST_N;
  logic        wen, creq;
  logic [3:0]  wreg, ra0, ra1;
  logic [15:0] wdata;
  int          tests, failed;

  regfile_mp_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) bus1 ();
  regfile_mp_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) bus0 ();

  assign bus1.writeData       = wdata;
  assign bus1.writeReg        = wreg;
  assign bus1.RegWriteControl = wen;
  assign bus1.readAddr        = {ra1, ra0};
  assign bus1.clearReq        = creq;
  assign bus0.writeData       = wdata;
  assign bus0.writeReg        = wreg;
  assign bus0.RegWriteControl = wen;
  assign bus0.readAddr        = {ra1, ra0};
  assign bus0.clearReq        = creq;

  regfile_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut_b1 (.CLK(CLK), .RST_N(RST_N), .bus(bus1));
  regfile_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b0))
    dut_b0 (.CLK(CLK), .RST_N(RST_N), .bus(bus0));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        wen;
    logic [3:0]  wreg;
    logic [15:0] wdata;
    logic [3:0]  ra0, ra1;
    logic [15:0] e1_0, e1_1, e0_0, e0_1;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  int busy_cnt;

  initial begin
    tests = 0; failed = 0;
    RST_N = 1'b0; wen = 1'b0; creq = 1'b0;
    wreg = '0; wdata = '0; ra0 = 4'd1; ra1 = 4'd2;

    //          wen  wreg   wdata      ra0    ra1    b1 p0      b1 p1      b0 p0      b0 p1
    tbl[0]  = '{1'b1, 4'd1,  16'h0001, 4'd2,  4'd1,  16'h0000, 16'h0001, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 4'd2,  16'h0008, 4'd2,  4'd1,  16'h0008, 16'h0001, 16'h0000, 16'h0001};
    tbl[2]  = '{1'b1, 4'd2,  16'h0005, 4'd2,  4'd1,  16'h0005, 16'h0001, 16'h0008, 16'h0001};
    tbl[3]  = '{1'b0, 4'd2,  16'h0000, 4'd2,  4'd1,  16'h0005, 16'h0001, 16'h0005, 16'h0001};
    tbl[4]  = '{1'b1, 4'd0,  16'hBEEF, 4'd0,  4'd0,  16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[5]  = '{1'b0, 4'd0,  16'h0000, 4'd0,  4'd0,  16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[6]  = '{1'b1, 4'd3,  16'h0007, 4'd3,  4'd3,  16'h0007, 16'h0007, 16'h0000, 16'h0000};
    tbl[7]  = '{1'b1, 4'd3,  16'h0042, 4'd3,  4'd3,  16'h0042, 16'h0042, 16'h0007, 16'h0007};
    tbl[8]  = '{1'b0, 4'd3,  16'h0000, 4'd3,  4'd3,  16'h0042, 16'h0042, 16'h0042, 16'h0042};
    tbl[9]  = '{1'b1, 4'd15, 16'hFFFF, 4'd15, 4'd14, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    tbl[10] = '{1'b0, 4'd15, 16'h0000, 4'd15, 4'd1,  16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001};

    // Reset state
    #12;
    chk("rst_rd_b1", {16'h0, bus1.readData}, 32'h0);
    chk("rst_rd_b0", {16'h0, bus0.readData}, 32'h0);
    chk("rst_busy", {31'h0, bus1.busy}, 32'h0);
    chk("rst_wrdrop", {31'h0, bus1.wrDropped}, 32'h0);
    RST_N = 1'b1;
    step();

    // Table: inputs held for one cycle, outputs checked before the committing edge
    for (int v = 0; v < 11; v++) begin
      wen = tbl[v].wen; wreg = tbl[v].wreg; wdata = tbl[v].wdata;
      ra0 = tbl[v].ra0; ra1 = tbl[v].ra1;
      #1;
      chk($sformatf("v%0d_b1_p0", v), {16'h0, bus1.readData[15:0]},  {16'h0, tbl[v].e1_0});
      chk($sformatf("v%0d_b1_p1", v), {16'h0, bus1.readData[31:16]}, {16'h0, tbl[v].e1_1});
      chk($sformatf("v%0d_b0_p0", v), {16'h0, bus0.readData[15:0]},  {16'h0, tbl[v].e0_0});
      chk($sformatf("v%0d_b0_p1", v), {16'h0, bus0.readData[31:16]}, {16'h0, tbl[v].e0_1});
      chk($sformatf("v%0d_wrdrop", v), {31'h0, bus1.wrDropped}, 32'h0);
      step();
    end
    wen = 1'b0;

    // Fill all registers with nonzero patterns
    for (int i = 0; i < 16; i++) begin
      wen = 1'b1; wreg = 4'(i); wdata = 16'h0100 + 16'(i);
      step();
    end
    wen = 1'b0;
    ra0 = 4'd0; #1;
    chk("fill_r0", {16'h0, bus1.readData[15:0]}, 32'h0);
    ra0 = 4'd9; #1;
    chk("fill_r9", {16'h0, bus1.readData[15:0]}, 32'h0109);

    // Clear sweep with a write on the clearReq edge, a dropped write, and an ignored clearReq
    wen = 1'b1; wreg = 4'd5; wdata = 16'hAAAA; creq = 1'b1;
    step();
    wen = 1'b0; creq = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus1.busy) busy_cnt++;
      creq = (c == 5);
      if (c == 1) begin
        ra0 = 4'd5; #1;
        chk("sweep_r5_committed", {16'h0, bus1.readData[15:0]}, 32'h0000AAAA);
      end
      if (c == 3) begin
        chk("sweep_wrdrop_pre", {31'h0, bus1.wrDropped}, 32'h0);
        wen = 1'b1; wreg = 4'd5; wdata = 16'h1234;
      end else begin
        wen = 1'b0;
      end
      if (c == 4) chk("sweep_wrdrop_pulse", {31'h0, bus1.wrDropped}, 32'h1);
      if (c == 5) chk("sweep_wrdrop_end", {31'h0, bus1.wrDropped}, 32'h0);
      if (c == 8) begin
        ra0 = 4'd7; ra1 = 4'd8; #1;
        chk("mid_r7_swept", {16'h0, bus1.readData[15:0]}, 32'h0);
        chk("mid_r8_kept", {16'h0, bus1.readData[31:16]}, 32'h0108);
      end
      if (c == 15) chk("busy_last", {31'h0, bus1.busy}, 32'h1);
      if (c == 16) chk("busy_done", {31'h0, bus1.busy}, 32'h0);
      step();
    end
    creq = 1'b0; wen = 1'b0;
    chk("busy_cycles", busy_cnt, 32'd16);
    for (int i = 0; i < 16; i++) begin
      ra0 = 4'(i); #1;
      chk($sformatf("post_r%0d", i), {16'h0, bus0.readData[15:0]}, 32'h0);
    end

    // Reset mid-sweep, asserted between edges
    wen = 1'b1; wreg = 4'd9; wdata = 16'h0099;
    step();
    wen = 1'b0; creq = 1'b1;
    step();
    creq = 1'b0;
    for (int c = 0; c < 8; c++) step();
    chk("pre_rst_busy", {31'h0, bus1.busy}, 32'h1);
    ra0 = 4'd9; #3;
    RST_N = 1'b0; #1;
    chk("async_rst_busy", {31'h0, bus1.busy}, 32'h0);
    chk("async_rst_r9", {16'h0, bus1.readData[15:0]}, 32'h0);
    #1 RST_N = 1'b1;
    wen = 1'b1; wreg = 4'd1; wdata = 16'h0077;
    step();
    wen = 1'b0; ra0 = 4'd1; #1;
    chk("post_rst_wr_r1", {16'h0, bus0.readData[15:0]}, 32'h0077);
    chk("post_rst_idle", {31'h0, bus1.busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
